// File: rtl/output_buffer_read_ctrl.sv
// Read-mode output buffer sequencer.
// For each ADC column of one PIM read result: present the column address,
// pulse the buffer write enable (LATCH), then hold the read enable (READ)
// and capture enc_i[3:0]. Eight nibbles are packed per 32-bit word, first
// column in bits [3:0]. Each word goes out over a valid/ready handshake.
//
// Output handshake: out_data_o / out_last_o are valid while out_valid_o is
// high and stay stable until the cycle in which out_ready_i is also high;
// the word is transferred on that rising clk_i edge.
module output_buffer_read_ctrl #(
    parameter int COL_STEP     = 4,
    parameter int NIB_PER_WORD = 8
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic [8:0]  col_addr_i,
    input  logic [7:0]  num_cols_i,
    input  logic        pim_valid_i,
    input  logic [31:0] enc_i,
    output logic        buf_w_en_o,
    output logic        buf_r_en_o,
    output logic [8:0]  col_addr9_o,
    output logic [31:0] out_data_o,
    output logic        out_valid_o,
    output logic        out_last_o,
    input  logic        out_ready_i,
    output logic        busy_o,
    output logic        done_o
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WAIT_PIM = 3'd1,
        S_LATCH    = 3'd2,
        S_READ     = 3'd3,
        S_PUSH     = 3'd4,
        S_DONE     = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic [8:0]  col_q;    // address of the next column to read
    logic [8:0]  addr_q;   // address driven during the current/last column
    logic [7:0]  rem_q;    // columns still to be read
    logic [3:0]  idx_q;    // nibble slot within the pack word
    logic [31:0] pack_q;

    logic last_nib;
    logic last_col;

    assign last_nib = (idx_q == 4'(NIB_PER_WORD - 1));
    assign last_col = (rem_q == 8'd1);

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) state_d = (num_cols_i == 8'd0) ? S_DONE : S_WAIT_PIM;
            end
            S_WAIT_PIM: begin
                if (pim_valid_i) state_d = S_LATCH;
            end
            S_LATCH: state_d = S_READ;
            S_READ: begin
                state_d = (last_nib || last_col) ? S_PUSH : S_LATCH;
            end
            S_PUSH: begin
                if (out_ready_i) state_d = (rem_q == 8'd0) ? S_DONE : S_LATCH;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Column walk, remaining count and nibble packing
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            col_q  <= '0;
            addr_q <= '0;
            rem_q  <= '0;
            idx_q  <= '0;
            pack_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        col_q  <= col_addr_i;
                        rem_q  <= num_cols_i;
                        idx_q  <= '0;
                        pack_q <= '0;
                    end
                end
                S_LATCH: addr_q <= col_q;
                S_READ: begin
                    pack_q[{idx_q[2:0], 2'b00} +: 4] <= enc_i[3:0];
                    idx_q <= idx_q + 4'd1;
                    rem_q <= rem_q - 8'd1;
                    col_q <= col_q + 9'(COL_STEP);
                end
                S_PUSH: begin
                    if (out_ready_i) begin
                        pack_q <= '0;
                        idx_q  <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs decoded from state; the address tracks col_q live in LATCH
    // and is held from the last LATCH everywhere else.
    always_comb begin
        buf_w_en_o  = (state_q == S_LATCH);
        buf_r_en_o  = (state_q == S_READ);
        col_addr9_o = (state_q == S_LATCH) ? col_q : addr_q;
        out_valid_o = (state_q == S_PUSH);
        out_last_o  = (state_q == S_PUSH) && (rem_q == 8'd0);
        out_data_o  = pack_q;
        busy_o      = (state_q != S_IDLE);
        done_o      = (state_q == S_DONE);
    end

endmodule

// File: doc/output_buffer_read_ctrl.md
Name: output_buffer_read_ctrl

Overview:
- Sequences the read-mode output buffer over a run of ADC columns for one PIM read result.
- Per column: drives the column address, pulses the buffer write enable, then asserts the buffer read enable and captures the 4-bit encoded result.
- Packs eight encoded nibbles per 32-bit word and hands words to the host/bus side over a valid/ready handshake.
- Sits between the PIM command logic and the read-mode output buffer.

Parameters:
- COL_STEP, 4, column-address increment per ADC; one ADC spans 4 column addresses.
- NIB_PER_WORD, 8, encoded 4-bit results packed per 32-bit output word; fixed at 8 (32/4).

Ports:
- clk_i  input  1  clock
- rst_ni  input  1  asynchronous active-low reset
- start_i  input  1  one-cycle command strobe; accepted only in IDLE
- col_addr_i  input  9  starting column address, sampled on accepted start
- num_cols_i  input  8  number of ADC columns to read, 0..128; sampled on accepted start
- pim_valid_i  input  1  PIM 1024-bit output is stable; must stay stable for the whole command
- enc_i  input  32  read-mode encoder output from the buffer; bits [3:0] used
- buf_w_en_o  output  1  buffer write enable
- buf_r_en_o  output  1  buffer read enable
- col_addr9_o  output  9  column address to the buffer
- out_data_o  output  32  packed result word
- out_valid_o  output  1  out_data_o valid
- out_last_o  output  1  final word of the command; qualified by out_valid_o
- out_ready_i  input  1  consumer accepts the word
- busy_o  output  1  high in every state except IDLE
- done_o  output  1  one-cycle pulse at command end

Behaviour:
- Reset (asynchronous, any state): state=IDLE. All outputs 0. Column register, remaining count, nibble index and pack register cleared.
- States: IDLE, WAIT_PIM, LATCH, READ, PUSH, DONE.
- IDLE:
  - start_i=1 latches col_addr_i and num_cols_i and clears the pack register.
  - If num_cols_i=0, go to DONE (no words emitted).
  - Otherwise go to WAIT_PIM.
- WAIT_PIM: stay while pim_valid_i=0; go to LATCH when it is 1. pim_valid_i is sampled only here, once per command.
- LATCH: buf_w_en_o=1 for exactly one cycle; col_addr9_o = current column. Next state READ.
- READ:
  - buf_r_en_o=1; col_addr9_o unchanged.
  - At the clock edge, enc_i[3:0] is written into nibble [4*idx+3:4*idx] of the pack register; idx increments; remaining count decrements; column += COL_STEP, modulo 512 (9-bit wrap, low bits preserved).
  - Next state PUSH if idx reaches 8 or the remaining count reaches 0; otherwise LATCH.
- PUSH:
  - out_valid_o=1, out_data_o = pack register. Unfilled upper nibbles are 0.
  - out_last_o=1 when the remaining count is 0.
  - Data and last are held stable until out_valid_o & out_ready_i.
  - On the handshake edge: clear the pack register and idx; go to DONE if remaining=0, else LATCH.
- DONE: done_o=1 for one cycle, then IDLE.
- col_addr9_o holds its last value outside LATCH/READ. buf_w_en_o and buf_r_en_o are never high simultaneously.
- start_i outside IDLE is ignored, with no effect on the running command.
- Timing with pim_valid_i already high and start accepted at edge k:
  - WAIT_PIM in cycle k+1; first buf_w_en_o in cycle k+2; first buf_r_en_o in cycle k+3.
  - Steady state is 2 cycles per column, plus at least 1 cycle per PUSH.
- Word order: first column result goes in bits [3:0], first word is emitted first.

Test Plan:
- col=0x000, num=1, buffer holds 8'b11110000 (enc=4), ready=1 -> w_en in cycle k+2 with addr 0x000; out_data=0x00000004, last=1; done pulse; busy back to 0.
- col=0x010, num=8, encodings 0,1,2,3,4,6,9,0 -> addresses 0x010,0x014..0x02C; single word 0x09643210 with last=1.
- num=10, all enc=9 -> word0 0x99999999 (last=0), word1 0x00000099 (last=1); exactly 10 w_en pulses.
- num=9, out_ready=0 for 5 cycles at first PUSH -> out_valid held, data stable, no w_en/r_en during the stall; resumes after ready.
- col=0x1FC, num=2 -> addresses 0x1FC then 0x000 (wrap).
- num=0 -> done one cycle after WAIT bypass, no out_valid. start pulsed while busy -> ignored. rst_ni low mid-READ -> all outputs 0 at once, IDLE; a new start then works normally.
